// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB requester bridging a valid/ready request/response port to an APB slave.
// Define APB_INITIATOR_TIMEOUT_EN to abort ACCESS phases that exceed timeout_cycles with an error response.
package apb_initiator_pkg;
    typedef struct packed {
        logic        pselx;
        logic        penable;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_in_type;
    localparam apb_in_type apb_in_none = '0;
    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;
endpackage

module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int timeout_cycles = 256
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_write,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    input  logic [2:0]  i_req_prot,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output apb_in_type  o_apbo,
    input  apb_out_type i_apbi
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;
    logic   done;
`ifdef APB_INITIATOR_TIMEOUT_EN
    logic [15:0] cnt;
    // a pready arriving on the expiry cycle still completes normally
    assign done = i_apbi.pready || cnt == 16'(timeout_cycles - 1);
`else
    assign done = i_apbi.pready;
`endif
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= IDLE;
            o_apbo       <= apb_in_none;
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (i_req_valid) begin
                    state       <= SETUP;
                    o_req_ready <= 1'b0;
                    o_apbo      <= '{pselx: 1'b1, penable: 1'b0, paddr: i_req_addr, pwrite: i_req_write,
                                     pwdata: i_req_wdata, pstrb: i_req_write ? i_req_wstrb : 4'h0,
                                     pprot: i_req_prot};
                end
                SETUP: begin
                    state          <= ACCESS;
                    o_apbo.penable <= 1'b1;
`ifdef APB_INITIATOR_TIMEOUT_EN
                    cnt            <= '0;
`endif
                end
                ACCESS: if (done) begin
                    state        <= RESP;
                    o_apbo       <= apb_in_none;
                    o_resp_valid <= 1'b1;
                    o_resp_rdata <= (i_apbi.pready && !o_apbo.pwrite) ? i_apbi.prdata : 32'h0;
                    o_resp_err   <= i_apbi.pready ? i_apbi.pslverr : 1'b1;
                end else begin
`ifdef APB_INITIATOR_TIMEOUT_EN
                    cnt <= cnt + 16'd1;
`endif
                end
                RESP: if (i_resp_ready) begin
                    state        <= IDLE;
                    o_req_ready  <= 1'b1;
                    o_resp_valid <= 1'b0;
                    o_resp_rdata <= '0;
                    o_resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed and randomized transactions checked against a transaction-level expectation of the APB initiator.
module tb_apb_initiator;
    import apb_initiator_pkg::*;
    localparam int TO = 8;
    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_write;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_wstrb;
    logic [2:0]  i_req_prot;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    apb_in_type  o_apbo;
    apb_out_type i_apbi;
    int n_chk = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    apb_initiator #(.timeout_cycles(TO)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_write(i_req_write), .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb), .i_req_prot(i_req_prot), .o_resp_valid(o_resp_valid),
        .i_resp_ready(i_resp_ready), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_apbo(o_apbo), .i_apbi(i_apbi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_apb(input string tag, input apb_in_type obs, input apb_in_type exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic junk_payload();
        i_req_addr  = $urandom;
        i_req_write = 1'($urandom);
        i_req_wdata = $urandom;
        i_req_wstrb = 4'($urandom);
        i_req_prot  = 3'($urandom);
    endtask

    // One full request/response exchange; expectations follow the protocol rules:
    // one SETUP cycle, waits+1 ACCESS cycles (or TO on timeout), then a response held for hold+1 cycles.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                       input logic [2:0] pr, input int waits, input logic se, input logic [31:0] rd,
                       input int hold, input bit keep, input bit to);
        apb_in_type e;
        int n_acc;
        n_acc = to ? TO : waits + 1;
        e = '{pselx: 1'b1, penable: 1'b0, paddr: a, pwrite: w, pwdata: wd, pstrb: w ? st : 4'h0, pprot: pr};
        chk("idle_req_ready", 32'(o_req_ready), 1);
        chk_apb("idle_apbo", o_apbo, apb_in_none);
        i_req_valid = 1'b1;
        i_req_addr = a; i_req_write = w; i_req_wdata = wd; i_req_wstrb = st; i_req_prot = pr;
        i_resp_ready = 1'b0;
        i_apbi = '{pready: 1'b1, prdata: $urandom, pslverr: 1'b1};
        tick();
        if (keep) junk_payload(); else i_req_valid = 1'b0;
        chk_apb("setup_apbo", o_apbo, e);
        chk("setup_req_ready", 32'(o_req_ready), 0);
        chk("setup_resp_valid", 32'(o_resp_valid), 0);
        i_apbi = '{pready: 1'b1, prdata: $urandom, pslverr: 1'b1};
        tick();
        e.penable = 1'b1;
        for (int k = 0; k < n_acc; k++) begin
            chk_apb("access_apbo", o_apbo, e);
            chk("access_resp_valid", 32'(o_resp_valid), 0);
            chk("access_req_ready", 32'(o_req_ready), 0);
            i_apbi.pready  = !to && k == waits;
            i_apbi.prdata  = (k == waits) ? rd : $urandom;
            i_apbi.pslverr = (k == waits) ? se : 1'($urandom);
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            i_apbi = '{pready: 1'($urandom), prdata: $urandom, pslverr: 1'($urandom)};
            chk("resp_valid", 32'(o_resp_valid), 1);
            chk("resp_rdata", o_resp_rdata, (to || w) ? 32'h0 : rd);
            chk("resp_err", 32'(o_resp_err), to ? 1 : 32'(se));
            chk("resp_req_ready", 32'(o_req_ready), 0);
            chk_apb("resp_apbo", o_apbo, apb_in_none);
            i_resp_ready = (h == hold);
            tick();
        end
        i_resp_ready = 1'b0;
        chk("post_resp_valid", 32'(o_resp_valid), 0);
        chk("post_req_ready", 32'(o_req_ready), 1);
        chk("post_rdata", o_resp_rdata, 0);
        chk("post_err", 32'(o_resp_err), 0);
    endtask

    initial begin
        i_nrst = 1'b0;
        i_req_valid = 1'b0;
        i_resp_ready = 1'b0;
        i_apbi = '0;
        junk_payload();
        tick();
        tick();
        chk("rst_req_ready", 32'(o_req_ready), 1);
        chk("rst_resp_valid", 32'(o_resp_valid), 0);
        chk("rst_rdata", o_resp_rdata, 0);
        chk("rst_err", 32'(o_resp_err), 0);
        chk_apb("rst_apbo", o_apbo, apb_in_none);
        i_nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            junk_payload();
            i_apbi = '{pready: 1'b1, prdata: $urandom, pslverr: 1'b1};
            tick();
            chk_apb("noreq_apbo", o_apbo, apb_in_none);
            chk("noreq_req_ready", 32'(o_req_ready), 1);
            chk("noreq_resp_valid", 32'(o_resp_valid), 0);
            chk("noreq_rdata", o_resp_rdata, 0);
        end
        txn(32'h1000_0010, 1'b0, $urandom, 4'($urandom), 3'($urandom), 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        txn(32'h20, 1'b1, 32'h1234_5678, 4'b0101, 3'd2, 3, 1'b0, $urandom, 0, 1'b0, 1'b0);
        txn(32'h40, 1'b0, $urandom, 4'hF, 3'd1, 1, 1'b1, 32'hCAFE_F00D, 4, 1'b0, 1'b0);
        txn(32'h100, 1'b1, 32'hAAAA_5555, 4'hF, 3'd0, 0, 1'b0, $urandom, 0, 1'b1, 1'b0);
        txn(32'h104, 1'b0, $urandom, 4'h3, 3'd7, 0, 1'b0, 32'h0BAD_CAFE, 0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), int'($urandom_range(0, 4)),
                1'($urandom), $urandom, int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
`ifdef APB_INITIATOR_TIMEOUT_EN
        txn(32'h300, 1'b0, $urandom, 4'hF, 3'd0, 0, 1'b0, $urandom, 1, 1'b0, 1'b1);
        txn(32'h304, 1'b0, $urandom, 4'hF, 3'd0, TO - 1, 1'b0, 32'h7777_1111, 0, 1'b0, 1'b0);
        txn(32'h308, 1'b1, 32'h5A5A_A5A5, 4'h9, 3'd3, 0, 1'b0, $urandom, 0, 1'b0, 1'b0);
`else
        txn(32'h300, 1'b0, $urandom, 4'hF, 3'd0, 3 * TO, 1'b0, 32'h1357_9BDF, 0, 1'b0, 1'b0);
`endif
        i_req_valid = 1'b1;
        i_req_addr = 32'h500; i_req_write = 1'b1; i_req_wdata = 32'h1; i_req_wstrb = 4'hF; i_req_prot = 3'd0;
        i_apbi = '0;
        tick();
        i_req_valid = 1'b0;
        tick();
        chk("pre_rst_psel", 32'(o_apbo.pselx), 1);
        #2 i_nrst = 1'b0;
        #1;
        chk_apb("rst_mid_apbo", o_apbo, apb_in_none);
        chk("rst_mid_req_ready", 32'(o_req_ready), 1);
        chk("rst_mid_resp_valid", 32'(o_resp_valid), 0);
        i_apbi = '{pready: 1'b1, prdata: 32'hFFFF_FFFF, pslverr: 1'b1};
        i_resp_ready = 1'b1;
        tick();
        #2 i_nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("after_rst_resp_valid", 32'(o_resp_valid), 0);
            chk("after_rst_req_ready", 32'(o_req_ready), 1);
            chk_apb("after_rst_apbo", o_apbo, apb_in_none);
        end
        i_resp_ready = 1'b0;
        txn(32'h600, 1'b0, $urandom, 4'h0, 3'd4, 2, 1'b0, 32'h2468_ACE0, 1, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL provide parameter timeout_cycles, default 256, ACCESS-phase cycles without pready before abort (range 2..65535).
REQ-002 SHALL provide port i_clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide port i_nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port i_req_valid  input  1  request present.
REQ-005 SHALL provide port o_req_ready  output  1  request accepted this cycle when both high.
REQ-006 SHALL provide ports i_req_addr  input  32, i_req_write  input  1, i_req_wdata  input  32, i_req_wstrb  input  4, i_req_prot  input  3 -- request payload.
REQ-007 SHALL provide port o_resp_valid  output  1  response present.
REQ-008 SHALL provide port i_resp_ready  input  1  response consumed when both high.
REQ-009 SHALL provide ports o_resp_rdata  output  32  read data, and o_resp_err  output  1  slave error or timeout.
REQ-010 SHALL provide port o_apbo  output  apb_in_type  APB request to slave.
REQ-011 SHALL provide port i_apbi  input  apb_out_type  APB response from slave.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-013 IDLE: o_req_ready=1; on i_req_valid latch addr/write/wdata/wstrb/prot, go SETUP.
REQ-014 SETUP: pselx=1, penable=0, paddr/pwrite/pprot/pwdata/pstrb from latched request; unconditionally to ACCESS next cycle.
REQ-015 ACCESS: pselx=1, penable=1, all other APB fields held stable until exit.
REQ-016 ACCESS with i_apbi.pready=1: capture prdata (reads) and pslverr into response registers, go RESP; pselx and penable low in the following cycle.
REQ-017 pstrb SHALL equal latched wstrb for writes and 4'h0 for reads; o_resp_rdata SHALL be 0 for writes.
REQ-018 RESP: o_resp_valid=1, rdata/err stable; on i_resp_ready go IDLE; o_req_ready=0 in all states except IDLE (no back-to-back overlap).
REQ-019 Minimum latency: request accepted cycle N, SETUP N+1, ACCESS N+2, o_resp_valid N+3 when pready high at N+2.
REQ-020 i_apbi SHALL be ignored outside ACCESS; pready in SETUP has no effect.
REQ-021 Requests with i_req_valid low in IDLE SHALL leave all outputs at reset values.

Reset
REQ-022 Assertion of i_nrst low SHALL asynchronously force IDLE, o_apbo = apb_in_none, o_req_ready=1, o_resp_valid=0, o_resp_rdata=0, o_resp_err=0, timeout counter=0.
REQ-023 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abandon the transfer with no response issued; pselx drops in the same cycle as reset assertion.

Configuration
REQ-024 Macro APB_INITIATOR_TIMEOUT_EN SHALL compile in a 16-bit ACCESS-cycle counter, cleared on ACCESS entry.
REQ-025 With APB_INITIATOR_TIMEOUT_EN: if counter reaches timeout_cycles-1 while pready=0, go RESP with o_resp_err=1, o_resp_rdata=0, pselx/penable dropped next cycle; pready on that same cycle wins (normal completion).
REQ-026 Without APB_INITIATOR_TIMEOUT_EN: no counter exists; ACCESS waits for pready indefinitely.

Verification
REQ-027 Read 0x1000_0010, slave pready=1 immediately with prdata=0xDEADBEEF -> SETUP/ACCESS one cycle each, o_resp_valid at N+3, rdata=0xDEADBEEF, err=0, pstrb=0.
REQ-028 Write 0x20, wdata=0x12345678, wstrb=4'b0101, slave 3 wait states -> pwdata/pstrb/paddr stable 5 cycles with psel, resp at N+6, rdata=0, err=0.
REQ-029 Read with pslverr=1 on pready cycle -> o_resp_err=1, rdata=captured prdata; i_resp_ready held low 4 cycles -> response held stable, o_req_ready=0 throughout.
REQ-030 APB_INITIATOR_TIMEOUT_EN, timeout_cycles=8, pready never asserted -> exactly 8 ACCESS cycles, resp err=1, rdata=0, psel low after; new request then completes normally.
REQ-031 Drive i_nrst low during ACCESS -> o_apbo=apb_in_none and o_req_ready=1 immediately, no o_resp_valid after release.
REQ-032 Back-to-back: i_req_valid held high with two requests, i_resp_ready=1 -> second accepted only the cycle after first response handshake.
